reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 4, is the clock-manager reset pulse length in clk cycles (>=1).
REQ-002 Parameter LOCK_TIMEOUT, default 1000, is the cycles spent waiting for lock before re-pulsing the clock-manager reset (>=2).
REQ-003 Parameter HOLD_CYCLES, default 16, is the consecutive synchronized-lock cycles required before release (>=1).
REQ-004 Parameter STAGE_GAP, default 8, is the cycles between successive stage reset releases (>=1).
REQ-005 clk  input  1  single free-running clock (the board clock also feeding the prescaler); all logic is on its rising edge.
REQ-006 n_rst  input  1  asynchronous, active-low reset.
REQ-007 locked  input  1  clock-manager lock status, asynchronous to clk.
REQ-008 sw_rst  input  1  synchronous, active-high software re-sequence request, sampled every cycle.
REQ-009 pll_n_rst  output  1  active-low reset to the prescaler, registered.
REQ-010 n_rst_out  output  3  active-low stage resets; bit 0 is released first and bit 2 last; registered.
REQ-011 ready  output  1  high only while all stages are released and lock holds, registered.
REQ-012 fault_cnt  output  8  saturating count of lock losses after release.

Function
REQ-013 locked SHALL pass through a 2-flop synchronizer (locked_s); all decisions use locked_s only.
REQ-014 The FSM SHALL have states PLL_RST, WAIT_LOCK, STABLE, RELEASE and RUN, with a single cycle counter wide enough for the largest parameter.
REQ-015 PLL_RST: pll_n_rst=0 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with pll_n_rst=1 on the same edge.
REQ-016 WAIT_LOCK: locked_s=1 goes to STABLE with counter cleared; otherwise, after LOCK_TIMEOUT cycles, go to PLL_RST.
REQ-017 STABLE: locked_s=0 goes to WAIT_LOCK (counter cleared, no fault count); HOLD_CYCLES consecutive locked_s=1 cycles go to RELEASE.
REQ-018 RELEASE entry edge: n_rst_out[0]=1; STAGE_GAP cycles later n_rst_out[1]=1; STAGE_GAP cycles after that n_rst_out[2]=1, ready=1, state RUN, all on the same edge.
REQ-019 Stage release SHALL be monotonic: a higher bit is never 1 while a lower bit is 0.
REQ-020 Lock loss (locked_s=0) in RELEASE or RUN: on the next edge n_rst_out=000, ready=0, fault_cnt increments (saturating at 255), state PLL_RST.
REQ-021 sw_rst=1 in any state: on the next edge n_rst_out=000, ready=0, state PLL_RST, fault_cnt unchanged.
REQ-022 sw_rst=1 together with lock loss in RELEASE or RUN SHALL behave as lock loss, so fault_cnt increments.
REQ-023 Worst-case latency from a locked pin fall to n_rst_out=000 SHALL be 3 clk cycles (2 synchronizer + 1 register).
REQ-024 In PLL_RST, WAIT_LOCK and STABLE: n_rst_out=000 and ready=0.

Reset
REQ-025 Reset is asynchronous and active-low: n_rst=0 immediately forces state PLL_RST, counter=0, pll_n_rst=0, n_rst_out=000, ready=0, fault_cnt=0 and both synchronizer flops=0.
REQ-026 After n_rst deasserts, the full PLL_RST_CYCLES pulse SHALL run before WAIT_LOCK.
REQ-027 n_rst assertion mid-RELEASE or mid-RUN SHALL drop all stage outputs without waiting for a clock edge.

Verification (defaults)
REQ-028 n_rst released, locked tied 1 -> pll_n_rst rises after 4 cycles; n_rst_out[0] rises 16 cycles after STABLE entry; [1] 8 cycles later; [2] and ready 8 cycles after that; fault_cnt=0.
REQ-029 locked tied 0 -> pll_n_rst low for 4 cycles, repeating with a period of 1004 cycles; n_rst_out stays 000.
REQ-030 locked drops for 2 cycles at STABLE count 10 -> return to WAIT_LOCK, and release starts only after a fresh 16-cycle hold.
REQ-031 locked falls in RUN -> n_rst_out=000 and ready=0 within 3 cycles, fault_cnt=1, pll_n_rst low for 4 cycles, then a full re-sequence.
REQ-032 300 lock-loss events -> fault_cnt saturates at 255 and never wraps.
REQ-033 n_rst pulsed low while n_rst_out=001, and separately sw_rst pulsed in RUN -> the first gives all reset values with no clock edge; the second gives n_rst_out=000 next edge with fault_cnt unchanged.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Brings up a clock manager and then releases three downstream reset
//   stages in order. The clock manager is reset for a fixed pulse and then
//   given a bounded time to lock. Lock must hold for a number of
//   consecutive cycles before stage 0 is released. Stage 1 follows after a
//   gap, and stage 2 plus ready follow after a second gap. Losing lock
//   after release counts a fault and restarts the whole sequence.
//
// Ports
//   clk        : free-running clock, rising edge
//   n_rst      : asynchronous active-low reset
//   locked     : clock-manager lock status (asynchronous, synchronized here)
//   sw_rst     : synchronous software re-sequence request
//   pll_n_rst  : active-low clock-manager reset (registered)
//   n_rst_out  : active-low stage resets, bit 0 released first (registered)
//   ready      : all stages released and lock holding (registered)
//   fault_cnt  : saturating count of lock losses after release
module reset_sequencer #(
    parameter int PLL_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 1000,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGE_GAP      = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       locked,
    input  logic       sw_rst,
    output logic       pll_n_rst,
    output logic [2:0] n_rst_out,
    output logic       ready,
    output logic [7:0] fault_cnt
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          locked_m;
    logic          locked_s;

    // Two-flop synchronizer for the lock status.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_n_rst <= 1'b0;
            n_rst_out <= '0;
            ready     <= 1'b0;
            fault_cnt <= '0;
        end else if ((state == RELEASE || state == RUN) && !locked_s) begin
            // Lock loss takes priority over sw_rst so the fault is counted.
            state     <= PLL_RST;
            cnt       <= '0;
            pll_n_rst <= 1'b0;
            n_rst_out <= '0;
            ready     <= 1'b0;
            if (fault_cnt != '1) begin
                fault_cnt <= fault_cnt + 8'd1;
            end
        end else if (sw_rst) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_n_rst <= 1'b0;
            n_rst_out <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_n_rst <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state     <= PLL_RST;
                        cnt       <= '0;
                        pll_n_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state     <= RELEASE;
                        cnt       <= '0;
                        n_rst_out <= 3'b001;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // The counter spans one gap; n_rst_out[1] tells which gap.
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (!n_rst_out[1]) begin
                            n_rst_out <= 3'b011;
                        end else begin
                            n_rst_out <= 3'b111;
                            ready     <= 1'b1;
                            state     <= RUN;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    cnt <= '0;
                end
                default: begin
                    state     <= PLL_RST;
                    cnt       <= '0;
                    pll_n_rst <= 1'b0;
                    n_rst_out <= '0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Self-checking bench for reset_sequencer with default parameters.
//   A phase/elapsed-time reference model derives the expected outputs
//   every cycle. Constant vector tables and directed sequences cover the
//   bring-up timeline, lock timeout, lock glitches, fault counting and
//   saturation, asynchronous reset and software re-sequence.
module tb_reset_sequencer;

    localparam int PRC = 4;
    localparam int LT  = 1000;
    localparam int HC  = 16;
    localparam int SG  = 8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       locked;
    logic       sw_rst;
    logic       pll_n_rst;
    logic [2:0] n_rst_out;
    logic       ready;
    logic [7:0] fault_cnt;

    always #5 clk = ~clk;

    reset_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LT),
        .HOLD_CYCLES   (HC),
        .STAGE_GAP     (SG)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .locked   (locked),
        .sw_rst   (sw_rst),
        .pll_n_rst(pll_n_rst),
        .n_rst_out(n_rst_out),
        .ready    (ready),
        .fault_cnt(fault_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = clock-manager reset, 1 = waiting for lock,
    // 2 = holding lock, 3 = released (stages derived from elapsed time).
    int   m_phase;
    int   m_t;
    int   m_fault;
    logic m_s1, m_s2, m_ls;

    task automatic model_step();
        m_ls = m_s2;
        m_s2 = m_s1;
        m_s1 = locked;
        if (m_phase == 3 && !m_ls) begin
            m_fault = (m_fault >= 255) ? 255 : m_fault + 1;
            m_phase = 0;
            m_t     = 0;
        end else if (sw_rst) begin
            m_phase = 0;
            m_t     = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_t++;
                    if (m_t == PRC) begin m_phase = 1; m_t = 0; end
                end
                1: begin
                    if (m_ls) begin m_phase = 2; m_t = 0; end
                    else begin
                        m_t++;
                        if (m_t == LT) begin m_phase = 0; m_t = 0; end
                    end
                end
                2: begin
                    if (!m_ls) begin m_phase = 1; m_t = 0; end
                    else begin
                        m_t++;
                        if (m_t == HC) begin m_phase = 3; m_t = 0; end
                    end
                end
                default: if (m_t < 2 * SG) m_t++;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) begin
                m_phase = 0; m_t = 0; m_fault = 0; m_s1 = 1'b0; m_s2 = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    function automatic logic [2:0] m_nro();
        int stages;
        if (m_phase != 3) return 3'b000;
        stages = 1 + m_t / SG;
        if (stages > 3) stages = 3;
        return 3'((1 << stages) - 1);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_pll", {31'd0, pll_n_rst}, {31'd0, (m_phase != 0)});
                chk("model_nro", {29'd0, n_rst_out}, {29'd0, m_nro()});
                chk("model_ready", {31'd0, ready}, {31'd0, (m_phase == 3 && m_t >= 2 * SG)});
                chk("model_fault", {24'd0, fault_cnt}, 32'(m_fault));
            end
        end
    end

    typedef struct {
        int         edge_n;
        logic       pll;
        logic [2:0] nro;
        logic       rdy;
        logic [7:0] fc;
    } vec_t;

    vec_t bring_up[10];
    vec_t glitch[3];

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic wait_phase(input int ph, input int budget, input string nm);
        int n;
        n = 0;
        while (m_phase != ph && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_phase != ph) begin
            errors++;
            $display("FAIL %s: timeout waiting for phase %0d, phase is %0d", nm, ph, m_phase);
        end
    endtask

    task automatic chk_vec(input string nm, input vec_t v);
        chk({nm, "_pll"}, {31'd0, pll_n_rst}, {31'd0, v.pll});
        chk({nm, "_nro"}, {29'd0, n_rst_out}, {29'd0, v.nro});
        chk({nm, "_ready"}, {31'd0, ready}, {31'd0, v.rdy});
        chk({nm, "_fault"}, {24'd0, fault_cnt}, {24'd0, v.fc});
    endtask

    initial begin
        int lost;
        n_rst  = 1'b0;
        locked = 1'b1;
        sw_rst = 1'b0;

        // Bring-up timeline with lock tied high, edges counted from release.
        bring_up[0] = '{0,  1'b0, 3'b000, 1'b0, 8'd0};
        bring_up[1] = '{3,  1'b0, 3'b000, 1'b0, 8'd0};
        bring_up[2] = '{4,  1'b1, 3'b000, 1'b0, 8'd0};
        bring_up[3] = '{20, 1'b1, 3'b000, 1'b0, 8'd0};
        bring_up[4] = '{21, 1'b1, 3'b001, 1'b0, 8'd0};
        bring_up[5] = '{28, 1'b1, 3'b001, 1'b0, 8'd0};
        bring_up[6] = '{29, 1'b1, 3'b011, 1'b0, 8'd0};
        bring_up[7] = '{36, 1'b1, 3'b011, 1'b0, 8'd0};
        bring_up[8] = '{37, 1'b1, 3'b111, 1'b1, 8'd0};
        bring_up[9] = '{50, 1'b1, 3'b111, 1'b1, 8'd0};

        // Lock pin low during edges 15-16: release slips to edge 35.
        glitch[0] = '{21, 1'b1, 3'b000, 1'b0, 8'd0};
        glitch[1] = '{34, 1'b1, 3'b000, 1'b0, 8'd0};
        glitch[2] = '{35, 1'b1, 3'b001, 1'b0, 8'd0};

        chk_en = 1'b1;
        do_reset();
        #1;
        for (int e = 0; e <= 50; e++) begin
            if (e > 0) @(negedge clk);
            for (int k = 0; k < 10; k++)
                if (bring_up[k].edge_n == e) chk_vec("bringup", bring_up[k]);
        end

        // Lock loss in RUN: outputs drop on the third edge.
        @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        chk("loss_e1_nro", {29'd0, n_rst_out}, 32'd7);
        @(negedge clk);
        chk("loss_e2_nro", {29'd0, n_rst_out}, 32'd7);
        chk("loss_e2_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        locked = 1'b1;
        chk("loss_e3_nro", {29'd0, n_rst_out}, 32'd0);
        chk("loss_e3_ready", {31'd0, ready}, 32'd0);
        chk("loss_e3_fault", {24'd0, fault_cnt}, 32'd1);
        chk("loss_e3_pll", {31'd0, pll_n_rst}, 32'd0);
        repeat (3) @(negedge clk);
        chk("loss_e6_pll", {31'd0, pll_n_rst}, 32'd0);
        @(negedge clk);
        chk("loss_e7_pll", {31'd0, pll_n_rst}, 32'd1);
        wait_phase(3, 200, "reseq");
        repeat (2 * SG) @(negedge clk);
        chk("reseq_nro", {29'd0, n_rst_out}, 32'd7);
        chk("reseq_ready", {31'd0, ready}, 32'd1);

        // Software re-sequence from RUN keeps the fault count.
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        chk("sw_nro", {29'd0, n_rst_out}, 32'd0);
        chk("sw_ready", {31'd0, ready}, 32'd0);
        chk("sw_pll", {31'd0, pll_n_rst}, 32'd0);
        chk("sw_fault", {24'd0, fault_cnt}, 32'd1);

        // Asynchronous reset while only stage 0 is released.
        wait_phase(3, 200, "to_stage0");
        chk("pre_arst_nro", {29'd0, n_rst_out}, 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_nro", {29'd0, n_rst_out}, 32'd0);
        chk("arst_pll", {31'd0, pll_n_rst}, 32'd0);
        chk("arst_ready", {31'd0, ready}, 32'd0);
        chk("arst_fault", {24'd0, fault_cnt}, 32'd0);
        chk("arst_sync", {30'd0, dut.locked_m, dut.locked_s}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Lock tied low: 4-cycle clock-manager pulse every 1004 cycles.
        locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 1010; e++) begin
            @(negedge clk);
            if (e == 4 || e == 1003 || e == 1008)
                chk("timeout_pll_hi", {31'd0, pll_n_rst}, 32'd1);
            if (e == 1004 || e == 1007)
                chk("timeout_pll_lo", {31'd0, pll_n_rst}, 32'd0);
            if (e == 1008)
                chk("timeout_nro", {29'd0, n_rst_out}, 32'd0);
        end

        // Short lock glitch during the hold window.
        locked = 1'b1;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            if (e == 14) locked = 1'b0;
            if (e == 16) locked = 1'b1;
            for (int k = 0; k < 3; k++)
                if (glitch[k].edge_n == e) chk_vec("glitch", glitch[k]);
        end

        // 300 lock losses: fault count saturates at 255.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            wait_phase(3, 200, "sat_release");
            locked = 1'b0;
            @(negedge clk);
            locked = 1'b1;
            lost = 0;
            while (m_phase == 3 && lost < 10) begin
                @(negedge clk);
                lost++;
            end
            chk("sat_count", {24'd0, fault_cnt}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        chk("sat_final", {24'd0, fault_cnt}, 32'd255);

        // Randomized lock and software-request activity against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) locked = ~locked;
            sw_rst = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        sw_rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
